// File: rtl/sd_cmd_sequencer.sv
// SD command sequencer: launches a command to the serial stage over a 4-phase REQ/ACK
// handshake and collects the status/response. Optional macro SD_CMD_INDEX_CHECK_EN adds a response index check.
module sd_cmd_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
  parameter logic [2:0]  WO_DELAY       = 3'd7
) (
  input  logic        SD_CLK_IN,
  input  logic        RST_IN,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  rsp_type,
  input  logic        crc_check,
  input  logic        blk_rd,
  input  logic        blk_wr,
  input  logic [1:0]  word_sel,
  output logic [15:0] SETTING_OUT,
  output logic [39:0] CMD_OUT,
  output logic        REQ_OUT,
  input  logic        ACK_IN,
  input  logic        REQ_IN,
  output logic        ACK_OUT,
  input  logic [7:0]  STATUS_IN,
  input  logic [39:0] RSP_IN,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic [31:0] rsp_word,
  output logic        crc_err,
  output logic        index_err,
  output logic        timeout_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]  state;
  logic        req_meta, req_s, req_d;
  logic        ack_meta, ack_s;
  logic [15:0] wait_cnt;
  logic [1:0]  rsp_type_q;
  logic        crc_check_q;
  logic [6:0]  rsp_len;
  logic        accept, complete, req_rise, rsp_present, timeout_hit;
  logic        unused_bits;

  // NOTE: every flop below is reset asynchronously by RST_IN and written with <= only.
  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
      req_d    <= 1'b0;
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      req_meta <= REQ_IN;
      req_s    <= req_meta;
      req_d    <= req_s;
      ack_meta <= ACK_IN;
      ack_s    <= ack_meta;
    end
  end

  always_comb begin
    rsp_len = 7'd0;
    case (rsp_type)
      2'b01:   rsp_len = 7'd40;
      2'b10:   rsp_len = 7'd127;
      default: rsp_len = 7'd0;
    endcase
  end

  assign req_rise    = req_s & ~req_d;
  assign accept      = (state == IDLE) & cmd_start & ack_s;
  assign complete    = (state == WAIT) & req_rise & STATUS_IN[6];
  assign rsp_present = (rsp_type_q == 2'b01) | (rsp_type_q == 2'b10);
  assign timeout_hit = (wait_cnt >= (TIMEOUT_CYCLES - 16'd1));
  assign unused_bits = ^{STATUS_IN[7], STATUS_IN[4:0], RSP_IN[39:32]};

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state       <= IDLE;
      SETTING_OUT <= 16'd0;
      CMD_OUT     <= 40'd0;
      REQ_OUT     <= 1'b0;
      ACK_OUT     <= 1'b0;
      cmd_busy    <= 1'b0;
      cmd_done    <= 1'b0;
      rsp_word    <= 32'd0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= 16'd0;
      rsp_type_q  <= 2'b00;
      crc_check_q <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            CMD_OUT     <= {2'b01, cmd_index, cmd_arg};
            SETTING_OUT <= {1'b0, word_sel, blk_rd, blk_wr, WO_DELAY, crc_check, rsp_len};
            REQ_OUT     <= 1'b1;
            cmd_busy    <= 1'b1;
            crc_err     <= 1'b0;
            timeout_err <= 1'b0;
            rsp_type_q  <= rsp_type;
            crc_check_q <= crc_check;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!ack_s) begin
            REQ_OUT  <= 1'b0;
            wait_cnt <= 16'd0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          ACK_OUT <= req_s;
          // Completion wins over a timeout landing in the same cycle.
          if (complete) begin
            if (rsp_present) rsp_word <= RSP_IN[31:0];
            crc_err <= rsp_present & crc_check_q & ~STATUS_IN[5];
            ACK_OUT <= 1'b1;
            state   <= DRAIN;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            ACK_OUT     <= 1'b1;
            state       <= DRAIN;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          if (ack_s) begin
            cmd_done <= 1'b1;
            cmd_busy <= 1'b0;
            ACK_OUT  <= 1'b0;
            state    <= IDLE;
          end else begin
            ACK_OUT <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef SD_CMD_INDEX_CHECK_EN
  logic index_mismatch;
  assign index_mismatch = (rsp_type_q == 2'b01) & (RSP_IN[37:32] != CMD_OUT[37:32]);

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN)        index_err <= 1'b0;
    else if (accept)   index_err <= 1'b0;
    else if (complete) index_err <= index_mismatch;
  end
`else
  assign index_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: a scripted serial-stage model plus a scoreboard of
// expected completion results, popped when cmd_done pulses.
module tb_sd_cmd_sequencer;

  typedef struct {
    logic [31:0] rsp;
    logic        crc;
    logic        idx;
    logic        tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [1:0]  rsp_type = '0;
  logic        crc_check = 1'b0;
  logic        blk_rd = 1'b0;
  logic        blk_wr = 1'b0;
  logic [1:0]  word_sel = '0;
  logic [15:0] setting_out;
  logic [39:0] cmd_out;
  logic        req_out;
  logic        ack_in = 1'b0;
  logic        req_in = 1'b0;
  logic        ack_out;
  logic [7:0]  status_in = '0;
  logic [39:0] rsp_in = '0;
  logic        cmd_busy, cmd_done;
  logic [31:0] rsp_word;
  logic        crc_err, index_err, timeout_err;

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  logic [31:0] last_rsp = '0;

  sd_cmd_sequencer #(.TIMEOUT_CYCLES(16'd16), .WO_DELAY(3'd7)) dut (
    .SD_CLK_IN(clk), .RST_IN(rst),
    .cmd_start(cmd_start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .rsp_type(rsp_type), .crc_check(crc_check), .blk_rd(blk_rd), .blk_wr(blk_wr),
    .word_sel(word_sel), .SETTING_OUT(setting_out), .CMD_OUT(cmd_out),
    .REQ_OUT(req_out), .ACK_IN(ack_in), .REQ_IN(req_in), .ACK_OUT(ack_out),
    .STATUS_IN(status_in), .RSP_IN(rsp_in), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .rsp_word(rsp_word), .crc_err(crc_err), .index_err(index_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return req_out;
      1:       return ack_out;
      2:       return cmd_done;
      default: return timeout_err;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic val, input int budget);
    for (int i = 0; i < budget && probe(sel) !== val; i++) tick();
    check(tag, probe(sel), val);
  endtask

  function automatic logic [15:0] exp_setting(input logic [1:0] rt, input logic crc,
                                              input logic br, input logic bw, input logic [1:0] ws);
    logic [6:0] len;
    len = (rt == 2'b01) ? 7'd40 : (rt == 2'b10) ? 7'd127 : 7'd0;
    return {1'b0, ws, br, bw, 3'd7, crc, len};
  endfunction

  task automatic launch(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input logic crc);
    cmd_index = idx; cmd_arg = arg; rsp_type = rt; crc_check = crc;
    blk_rd = 1'($urandom); blk_wr = 1'($urandom); word_sel = 2'($urandom);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("launch_req", req_out, 1'b1);
    check("launch_busy", cmd_busy, 1'b1);
    check("launch_cmd", cmd_out, {2'b01, idx, arg});
    check("launch_setting", setting_out, exp_setting(rt, crc, blk_rd, blk_wr, word_sel));
    check("launch_errs_clear", {crc_err, index_err, timeout_err}, 3'b000);
    ack_in = 1'b0;
    wait_for("req_drop", 0, 1'b0, 8);
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic crc, input logic [7:0] st, input logic [39:0] rsp,
                         input bit hang);
    exp_t e, got;
    logic present;
    int   d0;
    present = (rt == 2'b01) || (rt == 2'b10);
    if (hang) begin
      e.rsp = last_rsp; e.crc = 1'b0; e.idx = 1'b0; e.tmo = 1'b1;
    end else begin
      e.rsp = present ? rsp[31:0] : last_rsp;
      e.crc = present & crc & ~st[5];
`ifdef SD_CMD_INDEX_CHECK_EN
      e.idx = (rt == 2'b01) && (rsp[37:32] != idx);
`else
      e.idx = 1'b0;
`endif
      e.tmo = 1'b0;
    end
    last_rsp = e.rsp;
    sb.push_back(e);
    d0 = done_cnt;
    launch(idx, arg, rt, crc);
    if (hang) begin
      wait_for("timeout_flag", 3, 1'b1, 19);
    end else begin
      status_in = st; rsp_in = rsp; req_in = 1'b1;
      wait_for("ack_rise", 1, 1'b1, 8);
      req_in = 1'b0;
    end
    ack_in = 1'b1;
    wait_for("done_pulse", 2, 1'b1, 8);
    check("done_busy_low", cmd_busy, 1'b0);
    check("done_ack_low", ack_out, 1'b0);
    check("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check("rsp_word", rsp_word, got.rsp);
      check("crc_err", crc_err, got.crc);
      check("index_err", index_err, got.idx);
      check("timeout_err", timeout_err, got.tmo);
    end
    tick(3);
    check("single_done", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    tick(2);
    check("rst_setting", setting_out, 16'd0);
    check("rst_cmd", cmd_out, 40'd0);
    check("rst_flags", {req_out, ack_out, cmd_busy, cmd_done, crc_err, index_err, timeout_err}, 7'd0);
    check("rst_rsp", rsp_word, 32'd0);
    rst = 1'b0;

    // Serial stage not ready: launch must be ignored.
    tick(3);
    cmd_start = 1'b1; tick(); cmd_start = 1'b0; tick();
    check("ignored_busy", cmd_busy, 1'b0);
    check("ignored_req", req_out, 1'b0);

    ack_in = 1'b1; tick(3);
    run_cmd(6'd8, 32'h0000_01AA, 2'b01, 1'b1, 8'h66, 40'h08_0000_01AA, 1'b0);
    run_cmd(6'd0, 32'h0, 2'b00, 1'b0, 8'h44, 40'h00_DEAD_BEEF, 1'b0);
    check("none_len", setting_out[6:0], 7'd0);
    run_cmd(6'd17, 32'h1234_5678, 2'b01, 1'b1, 8'h46, 40'h11_CAFE_0001, 1'b0);
    run_cmd(6'd17, 32'h1234_5678, 2'b01, 1'b0, 8'h46, 40'h11_CAFE_0002, 1'b0);
    run_cmd(6'd2, 32'hFFFF_0000, 2'b10, 1'b1, 8'h66, 40'h3F_1357_9BDF, 1'b0);
    run_cmd(6'd55, 32'h0, 2'b11, 1'b1, 8'h44, 40'h00_0BAD_0BAD, 1'b0);
    run_cmd(6'd8, 32'h0000_01AA, 2'b01, 1'b0, 8'h66, 40'h09_0000_01AA, 1'b0);
    run_cmd(6'd13, 32'hA5A5_5A5A, 2'b01, 1'b1, 8'h00, 40'h0, 1'b1);

    // Reset in WAIT: abort with no completion, then resume.
    sb.push_back('{rsp: 32'h0, crc: 1'b0, idx: 1'b0, tmo: 1'b0});
    launch(6'd3, 32'h0000_0033, 2'b01, 1'b1);
    cmd_index = 6'd5; cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("busy_ignore_cmd", cmd_out[37:32], 6'd3);
    check("busy_ignore_busy", cmd_busy, 1'b1);
    d0 = done_cnt;
    rst = 1'b1; tick();
    check("abort_setting", setting_out, 16'd0);
    check("abort_cmd", cmd_out, 40'd0);
    check("abort_flags", {req_out, ack_out, cmd_busy, cmd_done, crc_err, index_err, timeout_err}, 7'd0);
    check("abort_rsp", rsp_word, 32'd0);
    rst = 1'b0;
    sb.delete();
    last_rsp = '0;
    tick(5);
    check("abort_no_done", done_cnt - d0, 0);
    ack_in = 1'b1; tick(3);
    run_cmd(6'd8, 32'h0000_01AA, 2'b01, 1'b1, 8'h66, 40'h08_0000_01AA, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
